// File: rtl/dmem_boot_loader.sv
// -----------------------------------------------------------------------------
// dmem_boot_loader
//
// Boot-time owner of the data-memory write port. After reset it takes a
// length-prefixed byte stream (LEN_LO, LEN_HI, then 4 bytes per word,
// little-endian) and writes the assembled 32-bit words to consecutive word
// addresses starting at 0. Once the last word is written it hands the memory
// port to the CPU and releases the CPU from reset. A reload pulse while done
// puts the CPU back in reset and restarts loading.
//
// Ports
//   clk           system clock (data_mem writes on the falling edge)
//   rst_n         asynchronous active-low reset
//   rx_valid      stream byte available on rx_data
//   rx_data       stream byte
//   rx_ready      loader accepts a byte this cycle
//   reload        single-cycle restart request, honoured only when done
//   cpu_a         CPU word address
//   cpu_we        CPU write enable (ignored until done)
//   cpu_d         CPU write data
//   mem_a         data_mem word address
//   mem_we        data_mem write enable
//   mem_d         data_mem write data
//   cpu_rst_n     active-low CPU reset, registered
//   load_done     loading finished, registered
//   words_loaded  words written by the current load
// -----------------------------------------------------------------------------
module dmem_boot_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_d,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_d,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Largest word count the memory can hold; 17 bits so ADDR_W=16 still fits.
  localparam logic [16:0]     MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WL_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_len_lo;
  logic [ADDR_W:0]   r_ne;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_word_buf;
  logic [ADDR_W:0]   r_words_loaded;
  logic              r_cpu_rst_n;
  logic              r_load_done;

  logic [16:0]       w_len;
  logic [16:0]       w_ne_full;
  logic [ADDR_W:0]   w_ne;
  logic              w_xfer;
  logic              w_last_word;

  // Effective word count, clamped to the memory depth so addresses never wrap.
  assign w_len       = {1'b0, rx_data, r_len_lo};
  assign w_ne_full   = (w_len > MAX_WORDS) ? MAX_WORDS : w_len;
  assign w_ne        = w_ne_full[ADDR_W:0];
  assign w_xfer      = rx_valid && rx_ready;
  assign w_last_word = ((r_words_loaded + WL_ONE) == r_ne);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, stream handshake and memory-port mux.
  always_comb begin
    w_next_state = r_state;
    rx_ready     = 1'b0;
    mem_we       = 1'b0;
    mem_a        = r_wr_addr;
    mem_d        = r_word_buf;
    case (r_state)
      S_LEN0: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          w_next_state = S_LEN1;
        end else begin
          w_next_state = S_LEN0;
        end
      end
      S_LEN1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (w_ne == '0) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_DATA;
          end
        end else begin
          w_next_state = S_LEN1;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && (r_byte_cnt == 2'd3)) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (w_last_word) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_DONE: begin
        // CPU owns the port only once loading is complete.
        mem_a  = cpu_a;
        mem_we = cpu_we;
        mem_d  = cpu_d;
        if (reload) begin
          w_next_state = S_LEN0;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_LEN0;
      end
    endcase
  end

  // Length capture, byte assembly and write-address / word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_lo       <= 8'd0;
      r_ne           <= '0;
      r_wr_addr      <= '0;
      r_byte_cnt     <= 2'd0;
      r_word_buf     <= 32'd0;
      r_words_loaded <= '0;
    end else begin
      case (r_state)
        S_LEN0: begin
          if (w_xfer) begin
            r_len_lo <= rx_data;
          end
        end
        S_LEN1: begin
          if (w_xfer) begin
            r_ne       <= w_ne;
            r_wr_addr  <= '0;
            r_byte_cnt <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            // First byte of a word lands in [7:0], fourth in [31:24].
            r_word_buf[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
            r_byte_cnt                            <= r_byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          r_words_loaded <= r_words_loaded + WL_ONE;
          // Hold the address on the final word so it never wraps past the top.
          if (!w_last_word) begin
            r_wr_addr <= r_wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          if (reload) begin
            r_words_loaded <= '0;
          end
        end
        default: begin
          r_byte_cnt <= 2'd0;
        end
      endcase
    end
  end

  // CPU reset and done flag follow the state being entered, so they change
  // on the same edge that enters or leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rst_n <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_cpu_rst_n <= (w_next_state == S_DONE);
      r_load_done <= (w_next_state == S_DONE);
    end
  end

  assign cpu_rst_n    = r_cpu_rst_n;
  assign load_done    = r_load_done;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_dmem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_dmem_boot_loader
//
// Bench for dmem_boot_loader. Two instances: the default ADDR_W=14 one for
// the main scenarios and an ADDR_W=2 one for the length clamp. Each has a
// falling-edge memory model; expected writes are queued when stimulus is
// driven and popped as the DUT writes.
// -----------------------------------------------------------------------------
module tb_dmem_boot_loader;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        reload;
  logic        rx_valid, rx_valid2;
  logic [7:0]  rx_data,  rx_data2;
  logic        rx_ready, rx_ready2;
  logic [13:0] cpu_a;
  logic        cpu_we;
  logic [31:0] cpu_d;
  logic [13:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_d;
  logic        cpu_rst_n, load_done;
  logic [14:0] words_loaded;
  logic [1:0]  mem_a2;
  logic        mem_we2;
  logic [31:0] mem_d2;
  logic        cpu_rst_n2, load_done2;
  logic [2:0]  words_loaded2;

  logic [31:0] mem  [0:16383];
  logic [31:0] mem2 [0:3];
  wr_t         exp_q[$];
  wr_t         exp_q2[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          wr_cnt2 = 0;
  int          cyc = 0;

  dmem_boot_loader #(.ADDR_W(14)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .cpu_a(cpu_a), .cpu_we(cpu_we),
    .cpu_d(cpu_d), .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .words_loaded(words_loaded)
  );

  dmem_boot_loader #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid2), .rx_data(rx_data2),
    .rx_ready(rx_ready2), .reload(1'b0), .cpu_a(2'd0), .cpu_we(1'b0),
    .cpu_d(32'd0), .mem_a(mem_a2), .mem_we(mem_we2), .mem_d(mem_d2),
    .cpu_rst_n(cpu_rst_n2), .load_done(load_done2), .words_loaded(words_loaded2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and scoreboard for the main instance.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      mem[mem_a] = mem_d;
      wr_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got a=%0h d=%h, required no write", mem_a, mem_d);
      end else begin
        e = exp_q.pop_front();
        if (mem_a !== e.a[13:0] || mem_d !== e.d) begin
          n_err++;
          $display("FAIL write: got a=%0h d=%h, required a=%0h d=%h", mem_a, mem_d, e.a[13:0], e.d);
        end
      end
    end
  end

  // Memory model and scoreboard for the clamp instance.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we2 === 1'b1) begin
      mem2[mem_a2] = mem_d2;
      wr_cnt2++;
      n_vec++;
      if (exp_q2.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write2: got a=%0h d=%h, required no write", mem_a2, mem_d2);
      end else begin
        e = exp_q2.pop_front();
        if (mem_a2 !== e.a[1:0] || mem_d2 !== e.d) begin
          n_err++;
          $display("FAIL write2: got a=%0h d=%h, required a=%0h d=%h", mem_a2, mem_d2, e.a[1:0], e.d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sel, input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    if (sel) exp_q2.push_back(e);
    else     exp_q.push_back(e);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    int wait_cnt;
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
    repeat (gap) tick();
    if (sel) begin
      rx_valid2 = 1'b1;
      rx_data2  = b;
    end else begin
      rx_valid  = 1'b1;
      rx_data   = b;
    end
    wait_cnt = 0;
    while (((sel ? rx_ready2 : rx_ready) !== 1'b1) && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    if (wait_cnt >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL rx_timeout: got rx_ready=0 for %0d cycles, required 1", wait_cnt);
    end
    tick();
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      send_byte(sel, w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b, required 1", rx_ready); end
    n_vec++;
    if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
    n_vec++;
    if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_cpu_rst_n: got %b, required 0", cpu_rst_n); end
    n_vec++;
    if (load_done !== 1'b0) begin n_err++; $display("FAIL reset_load_done: got %b, required 0", load_done); end
    n_vec++;
    if (words_loaded !== 15'd0) begin n_err++; $display("FAIL reset_words: got %0d, required 0", words_loaded); end
    n_vec++;
    #10 rst_n = 1'b1;
    if (rx_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got rx_ready=%b mem_we=%b, required 1/0", rx_ready, mem_we);
    end
    n_vec++;
    tick();
  endtask

  task automatic test_n2_load();
    int c0, w0;
    w0 = wr_cnt;
    push(1'b0, 16'd0, 32'h04030201);
    push(1'b0, 16'd1, 32'h08070605);
    send_byte(1'b0, 8'h02, 0);
    send_byte(1'b0, 8'h00, 0);
    c0 = cyc;
    send_word(1'b0, 32'h04030201, 0);
    send_word(1'b0, 32'h08070605, 0);
    if (mem_we !== 1'b1 || cpu_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL n2_last_write: got mem_we=%b cpu_rst_n=%b, required 1/0", mem_we, cpu_rst_n);
    end
    n_vec++;
    tick();
    if (cpu_rst_n !== 1'b1 || load_done !== 1'b1) begin
      n_err++;
      $display("FAIL n2_done: got cpu_rst_n=%b load_done=%b, required 1/1", cpu_rst_n, load_done);
    end
    n_vec++;
    if (words_loaded !== 15'd2) begin n_err++; $display("FAIL n2_words: got %0d, required 2", words_loaded); end
    n_vec++;
    if (cyc - c0 !== 10) begin n_err++; $display("FAIL n2_cycles: got %0d, required 10", cyc - c0); end
    n_vec++;
    if (mem[0] !== 32'h04030201 || mem[1] !== 32'h08070605) begin
      n_err++;
      $display("FAIL n2_image: got %h %h, required 04030201 08070605", mem[0], mem[1]);
    end
    n_vec++;
    if (wr_cnt - w0 !== 2 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL n2_pulses: got %0d writes, %0d pending, required 2, 0", wr_cnt - w0, exp_q.size());
    end
    n_vec++;
  endtask

  task automatic test_reload();
    if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL reload_pre: got %b, required 1", cpu_rst_n); end
    n_vec++;
    do_reload();
    if (cpu_rst_n !== 1'b0 || load_done !== 1'b0 || words_loaded !== 15'd0 || rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reload_edge: got cpu_rst_n=%b load_done=%b words=%0d rx_ready=%b, required 0/0/0/1",
               cpu_rst_n, load_done, words_loaded, rx_ready);
    end
    n_vec++;
    push(1'b0, 16'd0, 32'hAABBCCDD);
    send_byte(1'b0, 8'h01, 0);
    send_byte(1'b0, 8'h00, 0);
    send_word(1'b0, 32'hAABBCCDD, 0);
    tick();
    if (load_done !== 1'b1 || cpu_rst_n !== 1'b1 || words_loaded !== 15'd1) begin
      n_err++;
      $display("FAIL reload_done: got load_done=%b cpu_rst_n=%b words=%0d, required 1/1/1",
               load_done, cpu_rst_n, words_loaded);
    end
    n_vec++;
    if (mem[0] !== 32'hAABBCCDD || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL reload_image: got %h (%0d pending), required aabbccdd (0)", mem[0], exp_q.size());
    end
    n_vec++;
  endtask

  task automatic test_n0();
    int w0;
    do_reload();
    w0 = wr_cnt;
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 0);
    if (load_done !== 1'b1 || cpu_rst_n !== 1'b1 || words_loaded !== 15'd0) begin
      n_err++;
      $display("FAIL n0_done: got load_done=%b cpu_rst_n=%b words=%0d, required 1/1/0",
               load_done, cpu_rst_n, words_loaded);
    end
    n_vec++;
    repeat (3) tick();
    if (wr_cnt !== w0 || rx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL n0_idle: got %0d writes rx_ready=%b, required 0 writes rx_ready=0", wr_cnt - w0, rx_ready);
    end
    n_vec++;
  endtask

  task automatic test_stall_isolation();
    do_reload();
    cpu_a  = 14'd5;
    cpu_d  = 32'hDEADBEEF;
    cpu_we = 1'b1;
    push(1'b0, 16'd0, 32'h04030201);
    push(1'b0, 16'd1, 32'h08070605);
    send_byte(1'b0, 8'h02, int'($urandom_range(5, 0)));
    send_byte(1'b0, 8'h00, int'($urandom_range(5, 0)));
    send_word(1'b0, 32'h04030201, 5);
    send_word(1'b0, 32'h08070605, 5);
    push(1'b0, 16'd5, 32'hDEADBEEF);
    tick();
    if (load_done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b, required 1", load_done); end
    n_vec++;
    @(negedge clk);
    #1;
    cpu_we = 1'b0;
    if (mem[0] !== 32'h04030201 || mem[1] !== 32'h08070605) begin
      n_err++;
      $display("FAIL stall_image: got %h %h, required 04030201 08070605", mem[0], mem[1]);
    end
    n_vec++;
    if (mem[5] !== 32'hDEADBEEF || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL cpu_write: got %h (%0d pending), required deadbeef (0)", mem[5], exp_q.size());
    end
    n_vec++;
    tick();
  endtask

  task automatic test_reset_midload();
    do_reload();
    push(1'b0, 16'd0, 32'h11223344);
    send_byte(1'b0, 8'h02, 0);
    send_byte(1'b0, 8'h00, 0);
    send_word(1'b0, 32'h11223344, 0);
    send_byte(1'b0, 8'hAA, 0);
    send_byte(1'b0, 8'hBB, 0);
    if (words_loaded !== 15'd1) begin n_err++; $display("FAIL midload_pre: got %0d, required 1", words_loaded); end
    n_vec++;
    rst_n = 1'b0;
    #1;
    if (cpu_rst_n !== 1'b0 || load_done !== 1'b0 || words_loaded !== 15'd0 || rx_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL midload_reset: got cpu_rst_n=%b load_done=%b words=%0d rx_ready=%b mem_we=%b, required 0/0/0/1/0",
               cpu_rst_n, load_done, words_loaded, rx_ready, mem_we);
    end
    n_vec++;
    rst_n = 1'b1;
    tick();
    push(1'b0, 16'd0, 32'h55667788);
    send_byte(1'b0, 8'h01, 0);
    send_byte(1'b0, 8'h00, 0);
    send_word(1'b0, 32'h55667788, 0);
    tick();
    if (load_done !== 1'b1 || words_loaded !== 15'd1) begin
      n_err++;
      $display("FAIL midload_done: got load_done=%b words=%0d, required 1/1", load_done, words_loaded);
    end
    n_vec++;
    if (mem[0] !== 32'h55667788 || mem[1] !== 32'h08070605 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL midload_image: got %h %h (%0d pending), required 55667788 08070605 (0)",
               mem[0], mem[1], exp_q.size());
    end
    n_vec++;
  endtask

  task automatic test_clamp();
    logic [31:0] w;
    send_byte(1'b1, 8'hFF, 0);
    send_byte(1'b1, 8'hFF, 0);
    for (int i = 0; i < 4; i++) begin
      w = 32'h03020100 + 32'h04040404 * 32'(i);
      push(1'b1, 16'(i), w);
      send_word(1'b1, w, 0);
    end
    tick();
    if (load_done2 !== 1'b1 || cpu_rst_n2 !== 1'b1 || words_loaded2 !== 3'd4) begin
      n_err++;
      $display("FAIL clamp_done: got load_done=%b cpu_rst_n=%b words=%0d, required 1/1/4",
               load_done2, cpu_rst_n2, words_loaded2);
    end
    n_vec++;
    for (int i = 0; i < 4; i++) begin
      w = 32'h03020100 + 32'h04040404 * 32'(i);
      if (mem2[i] !== w) begin n_err++; $display("FAIL clamp_mem%0d: got %h, required %h", i, mem2[i], w); end
      n_vec++;
    end
    rx_valid2 = 1'b1;
    rx_data2  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      if (rx_ready2 !== 1'b0) begin n_err++; $display("FAIL clamp_17th: got rx_ready=%b, required 0", rx_ready2); end
      n_vec++;
      tick();
    end
    rx_valid2 = 1'b0;
    if (wr_cnt2 !== 4 || exp_q2.size() !== 0 || load_done2 !== 1'b1) begin
      n_err++;
      $display("FAIL clamp_writes: got %0d writes %0d pending load_done=%b, required 4, 0, 1",
               wr_cnt2, exp_q2.size(), load_done2);
    end
    n_vec++;
  endtask

  initial begin
    rst_n     = 1'b0;
    reload    = 1'b0;
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
    rx_data   = 8'h00;
    rx_data2  = 8'h00;
    cpu_a     = 14'd0;
    cpu_we    = 1'b0;
    cpu_d     = 32'd0;
    test_reset();
    test_n2_load();
    test_reload();
    test_n0();
    test_stall_isolation();
    test_reset_midload();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
